// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: default datapath width and opcode encodings.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADDU = 4'b0010,
        OP_ADD  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLTU = 4'b0110,
        OP_SUBU = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_SLL  = 4'b1001,
        OP_SRL  = 4'b1010
    } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: computes a + b, or a + ~b + 1 when sub is set,
// with carry out of the top bit and signed overflow.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] bx;

    always_comb begin
        bx          = sub ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        // Checking against the inverted operand covers both add and subtract overflow.
        ovf         = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// Execute-stage integer ALU: logic, add/sub, compares and logical shifts,
// one-cycle latency with registered result and flags.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic             Carryout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Set
);

    localparam int               SHW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             big_shift;

    logic [WIDTH-1:0] res_n;
    logic             c_n;
    logic             v_n;
    logic             s_n;

    assign sub = (Op == OP_SUB) || (Op == OP_SUBU) || (Op == OP_SLT) || (Op == OP_SLTU);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .sub  (sub),
        .a    (A),
        .b    (B),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    // Shift counts use all of B; anything at or beyond WIDTH clears the result.
    assign big_shift = (B >= WLIM);

    always_comb begin
        res_n = '0;
        c_n   = 1'b0;
        v_n   = 1'b0;
        s_n   = 1'b0;
        case (Op)
            OP_AND:  res_n = A & B;
            OP_OR:   res_n = A | B;
            OP_XOR:  res_n = A ^ B;
            OP_ADDU, OP_SUBU: begin
                res_n = sum;
                c_n   = cout;
            end
            OP_ADD, OP_SUB: begin
                res_n = sum;
                c_n   = cout;
                v_n   = ovf;
            end
            OP_SLT: begin
                c_n   = cout;
                s_n   = sum[WIDTH-1] ^ ovf;
                res_n = {{(WIDTH-1){1'b0}}, s_n};
            end
            OP_SLTU: begin
                c_n   = cout;
                s_n   = ~cout;
                res_n = {{(WIDTH-1){1'b0}}, s_n};
            end
            OP_SLL:  res_n = big_shift ? '0 : (A << B[SHW-1:0]);
            OP_SRL:  res_n = big_shift ? '0 : (A >> B[SHW-1:0]);
            default: res_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Result    <= '0;
            Carryout  <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b1;
            Set       <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            Result    <= res_n;
            Carryout  <= c_n;
            Overflow  <= v_n;
            Zero      <= (res_n == '0);
            Set       <= s_n;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, randomized ops against
// an arithmetic reference model, and control-path sequences.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] A, B;
    logic [3:0]  Op;
    logic        out_valid;
    logic [31:0] Result;
    logic        Carryout, Overflow, Zero, Set;

    int n_checks = 0;
    int n_fail   = 0;

    alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .out_valid (out_valid),
        .Result    (Result),
        .Carryout  (Carryout),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .Set       (Set)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        s;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural values.
    function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_t            e;
        longint          sa, sb, sr;
        longint unsigned ua, ub, full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        e.op = op; e.a = a; e.b = b;
        e.r = 32'h0; e.c = 1'b0; e.v = 1'b0; e.s = 1'b0;
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b1000: e.r = a ^ b;
            4'b0010, 4'b0011: begin
                full = ua + ub;
                e.r  = full[31:0];
                e.c  = full[32];
                sr   = sa + sb;
                if (op == 4'b0011) e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0100, 4'b0111: begin
                e.r = a - b;
                e.c = (ua >= ub);
                sr  = sa - sb;
                if (op == 4'b0100) e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0101: begin
                e.s = (sa < sb);
                e.c = (ua >= ub);
                e.r = {31'b0, e.s};
            end
            4'b0110: begin
                e.s = (ua < ub);
                e.c = (ua >= ub);
                e.r = {31'b0, e.s};
            end
            4'b1001: e.r = (ub >= 32) ? 32'h0 : (a << ub);
            4'b1010: e.r = (ub >= 32) ? 32'h0 : (a >> ub);
            default: e.r = 32'h0;
        endcase
        e.z = (e.r == 32'h0);
        return e;
    endfunction

    task automatic check_outs(input string tag, input vec_t e);
        chk({tag, " out_valid"}, {31'b0, out_valid}, 32'h1);
        chk({tag, " Result"},    Result,             e.r);
        chk({tag, " Carryout"},  {31'b0, Carryout},  {31'b0, e.c});
        chk({tag, " Overflow"},  {31'b0, Overflow},  {31'b0, e.v});
        chk({tag, " Zero"},      {31'b0, Zero},      {31'b0, e.z});
        chk({tag, " Set"},       {31'b0, Set},       {31'b0, e.s});
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        Op = op; A = a; B = b;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic c, input logic v,
                                input logic z, input logic s);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.r = r; t.c = c; t.v = v; t.z = z; t.s = s;
        return t;
    endfunction

    initial begin
        vec_t        e;
        logic [31:0] hold_r;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; Op = 4'h0; A = 32'h0; B = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset Result",    Result,             32'h0);
        chk("reset Zero",      {31'b0, Zero},      32'h1);
        chk("reset flags",     {29'b0, Carryout, Overflow, Set}, 32'h0);
        rst = 1'b0;

        tbl.push_back(mk(OP_ADDU, 32'h0000003f, 32'h0000ffff, 32'h0001003e, 0, 0, 0, 0));
        tbl.push_back(mk(OP_SUBU, 32'h1fffffff, 32'h00000006, 32'h1ffffff9, 1, 0, 0, 0));
        tbl.push_back(mk(OP_ADD,  32'h0000003f, 32'h7fffffff, 32'h8000003e, 0, 1, 0, 0));
        tbl.push_back(mk(OP_ADD,  32'hffffffff, 32'h7fffffff, 32'h7ffffffe, 1, 0, 0, 0));
        tbl.push_back(mk(OP_SUB,  32'h8fffffff, 32'h80000000, 32'h0fffffff, 1, 0, 0, 0));
        tbl.push_back(mk(OP_SUB,  32'h7fffffff, 32'hffffffff, 32'h80000000, 0, 1, 0, 0));
        tbl.push_back(mk(OP_SLL,  32'haaaaaaaa, 32'h00000006, 32'haaaaaa80, 0, 0, 0, 0));
        tbl.push_back(mk(OP_SLL,  32'haaaaaaaa, 32'h0000001f, 32'h00000000, 0, 0, 1, 0));
        tbl.push_back(mk(OP_SRL,  32'haaaaaaaa, 32'h0000001f, 32'h00000001, 0, 0, 0, 0));
        tbl.push_back(mk(OP_SLL,  32'h00001000, 32'h00001000, 32'h00000000, 0, 0, 1, 0));
        tbl.push_back(mk(OP_SRL,  32'h80000000, 32'h00000020, 32'h00000000, 0, 0, 1, 0));
        tbl.push_back(mk(OP_OR,   32'hffffffff, 32'h00000011, 32'hffffffff, 0, 0, 0, 0));
        tbl.push_back(mk(OP_AND,  32'hfff00001, 32'h0000011f, 32'h00000001, 0, 0, 0, 0));
        tbl.push_back(mk(OP_XOR,  32'hffff0000, 32'h00000011, 32'hffff0011, 0, 0, 0, 0));
        tbl.push_back(mk(OP_SLT,  32'h1aaaaaa1, 32'h1aaaaaaa, 32'h00000001, 0, 0, 0, 1));
        tbl.push_back(mk(OP_SLT,  32'h2aaaaaaa, 32'h1aaaaaaa, 32'h00000000, 1, 0, 1, 0));
        tbl.push_back(mk(OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1, 0, 0, 1));
        tbl.push_back(mk(OP_SLTU, 32'h80000000, 32'h80000001, 32'h00000001, 0, 0, 0, 1));
        tbl.push_back(mk(OP_SLTU, 32'h12345678, 32'h12345678, 32'h00000000, 1, 0, 1, 0));
        tbl.push_back(mk(4'b1111, 32'hffffffff, 32'h00000001, 32'h00000000, 0, 0, 1, 0));
        tbl.push_back(mk(4'b1011, 32'h12345678, 32'h00000003, 32'h00000000, 0, 0, 1, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            check_outs($sformatf("vec%0d op%h", i, tbl[i].op), tbl[i]);
        end

        // Back-to-back randomized operations, one result per cycle.
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 40));
                1:       rb = ra;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = {ra[31], 31'h7fffffff ^ {31{ra[30]}}};
            e = model(rop, ra, rb);
            drive(rop, ra, rb);
            check_outs($sformatf("rand%0d op%h", i, rop), e);
        end

        // Idle cycles: outputs hold, out_valid drops.
        e = model(OP_ADD, 32'h0000003f, 32'h7fffffff);
        drive(OP_ADD, 32'h0000003f, 32'h7fffffff);
        check_outs("pre-hold", e);
        hold_r = e.r;
        in_valid = 1'b0; Op = OP_AND; A = 32'h0; B = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d out_valid", i), {31'b0, out_valid}, 32'h0);
            chk($sformatf("hold%0d Result", i),    Result,             hold_r);
            chk($sformatf("hold%0d Overflow", i),  {31'b0, Overflow},  32'h1);
            chk($sformatf("hold%0d Zero", i),      {31'b0, Zero},      32'h0);
        end

        // Reset asserted alongside a valid capture: reset wins.
        drive(OP_SLTU, 32'h00000001, 32'h00000002);
        rst = 1'b1;
        drive(OP_ADD, 32'hffffffff, 32'h7fffffff);
        chk("rst+valid out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst+valid Result",    Result,             32'h0);
        chk("rst+valid Zero",      {31'b0, Zero},      32'h1);
        chk("rst+valid flags",     {29'b0, Carryout, Overflow, Set}, 32'h0);
        rst = 1'b0;
        in_valid = 1'b0;

        e = model(OP_SUBU, 32'h00000005, 32'h00000007);
        drive(OP_SUBU, 32'h00000005, 32'h00000007);
        check_outs("post-reset", e);
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
